// File: rtl/pbit_sched_pkg.sv
// Shared definitions for the p-bit sweep scheduler: FSM state encoding and
// default widths/timing used by the scheduler and its anneal sub-block.
package pbit_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    UPDATE,
    SETTLE,
    SWEEP_END,
    DONE
  } sched_state_t;

  localparam int DEFAULT_SHIFT_W       = 2;
  localparam int DEFAULT_SETTLE_CYCLES = 2;

endpackage

// File: rtl/pbit_anneal_counter.sv
// Anneal step generator: counts completed sweeps since the last step and
// cools bit_shift by one (saturating at zero) every sweeps_per_step sweeps.
// A sweeps_per_step of zero disables stepping entirely.
module pbit_anneal_counter
  import pbit_sched_pkg::*;
#(
  parameter int SWEEP_W = 16,
  parameter int SHIFT_W = DEFAULT_SHIFT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [SHIFT_W-1:0] shift_init,
  input  logic [SWEEP_W-1:0] sweeps_per_step,
  input  logic               sweep_end,
  output logic [SHIFT_W-1:0] bit_shift
);

  logic [SWEEP_W-1:0] step_count;

  // Restart the step count at each run start, then step once per full interval
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_count <= '0;
      bit_shift  <= '0;
    end else if (load) begin
      step_count <= '0;
      bit_shift  <= shift_init;
    end else if (sweep_end && (sweeps_per_step != '0)) begin
      if (step_count == (sweeps_per_step - SWEEP_W'(1))) begin
        step_count <= '0;
        if (bit_shift != '0) begin
          bit_shift <= bit_shift - SHIFT_W'(1);
        end
      end else begin
        step_count <= step_count + SWEEP_W'(1);
      end
    end
  end

endmodule

// File: rtl/pbit_sweep_scheduler.sv
// Sequencing controller for p-bit gate systems. Strobes each p-bit's update
// enable in fixed order, waits SETTLE_CYCLES after each strobe, captures a
// sample after every full sweep and optionally anneals bit_shift.
// Optional feature macro: PBIT_SCHED_ANNEAL_EN (bit_shift annealing).
// All outputs are registered by decoding the next state, so each output is
// valid in the same cycle the FSM occupies the corresponding state.
module pbit_sweep_scheduler
  import pbit_sched_pkg::*;
#(
  parameter int N_PBITS       = 5,
  parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
  parameter int SWEEP_W       = 16,
  parameter int SHIFT_W       = DEFAULT_SHIFT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic [SWEEP_W-1:0] n_sweeps,
  input  logic [SWEEP_W-1:0] sweeps_per_step,
  input  logic [SHIFT_W-1:0] bit_shift_init,
  input  logic [N_PBITS-1:0] pbit_state,
  output logic [N_PBITS-1:0] update_en,
  output logic [SHIFT_W-1:0] bit_shift,
  output logic [N_PBITS-1:0] sample,
  output logic               sample_valid,
  output logic [SWEEP_W-1:0] sweep_count,
  output logic               busy,
  output logic               done
);

  localparam int IDX_W = (N_PBITS > 1) ? $clog2(N_PBITS) : 1;
  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(N_PBITS - 1);
  localparam logic [SET_W-1:0] LAST_SETTLE =
    SET_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  sched_state_t       state, next_state;
  logic [IDX_W-1:0]   index, next_index;
  logic [SET_W-1:0]   settle_cnt, next_settle;
  logic [SWEEP_W-1:0] n_sweeps_q;
  logic               start_run;
  logic               sweep_end_evt;

  // Next-state logic; stop overrides every transition out of a busy state
  always_comb begin
    next_state  = state;
    next_index  = index;
    next_settle = settle_cnt;
    start_run   = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          start_run  = 1'b1;
          next_index = '0;
          next_state = UPDATE;
        end
      end
      UPDATE: begin
        if (SETTLE_CYCLES == 0) begin
          if (index == LAST_IDX) begin
            next_state = SWEEP_END;
          end else begin
            next_index = index + 1'b1;
            next_state = UPDATE;
          end
        end else begin
          next_settle = '0;
          next_state  = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt == LAST_SETTLE) begin
          if (index == LAST_IDX) begin
            next_state = SWEEP_END;
          end else begin
            next_index = index + 1'b1;
            next_state = UPDATE;
          end
        end else begin
          next_settle = settle_cnt + 1'b1;
        end
      end
      SWEEP_END: begin
        if ((n_sweeps_q != '0) && (sweep_count == n_sweeps_q)) begin
          next_state = DONE;
        end else begin
          next_index = '0;
          next_state = UPDATE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (stop && (state != IDLE)) begin
      next_state = IDLE;
    end
  end

  assign sweep_end_evt = (next_state == SWEEP_END);

  // FSM state, p-bit index and settle counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      index      <= '0;
      settle_cnt <= '0;
    end else begin
      state      <= next_state;
      index      <= next_index;
      settle_cnt <= next_settle;
    end
  end

  // Registered outputs decoded from the upcoming state, plus run bookkeeping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      update_en    <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
      sweep_count  <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      n_sweeps_q   <= '0;
    end else begin
      update_en    <= (next_state == UPDATE) ? (N_PBITS'(1) << next_index) : '0;
      sample_valid <= sweep_end_evt;
      busy         <= (next_state != IDLE);
      done         <= (next_state == DONE);
      if (sweep_end_evt) begin
        sample <= pbit_state;
      end
      if (start_run) begin
        n_sweeps_q  <= n_sweeps;
        sweep_count <= '0;
      end else if (sweep_end_evt) begin
        sweep_count <= sweep_count + 1'b1;
      end
    end
  end

`ifdef PBIT_SCHED_ANNEAL_EN
  logic [SWEEP_W-1:0] sps_q;

  // Hold the anneal interval for the duration of the run
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sps_q <= '0;
    end else if (start_run) begin
      sps_q <= sweeps_per_step;
    end
  end

  pbit_anneal_counter #(
    .SWEEP_W (SWEEP_W),
    .SHIFT_W (SHIFT_W)
  ) u_anneal (
    .clk             (clk),
    .reset           (reset),
    .load            (start_run),
    .shift_init      (bit_shift_init),
    .sweeps_per_step (sps_q),
    .sweep_end       (sweep_end_evt),
    .bit_shift       (bit_shift)
  );
`else
  logic unused_sps;
  assign unused_sps = ^sweeps_per_step;

  // Without annealing bit_shift is simply the value latched at run start
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_shift <= '0;
    end else if (start_run) begin
      bit_shift <= bit_shift_init;
    end
  end
`endif

endmodule

// File: tb/tb_pbit_sweep_scheduler.sv
// Self-checking bench for pbit_sweep_scheduler. Expected values come from an
// arithmetic model of the sweep schedule (cycle position within a sweep).
module tb_pbit_sweep_scheduler;

  localparam int N   = 5;
  localparam int S   = 2;
  localparam int SW  = 16;
  localparam int SHW = 2;
  localparam int L   = N * (1 + S) + 1;

  logic          clk;
  logic          reset;
  logic          start;
  logic          start_0;
  logic          stop;
  logic [SW-1:0] n_sweeps;
  logic [SW-1:0] sweeps_per_step;
  logic [SHW-1:0] bit_shift_init;
  logic [N-1:0]  pbit_state;

  logic [N-1:0]   update_en,   update_en_0;
  logic [SHW-1:0] bit_shift,   bit_shift_0;
  logic [N-1:0]   sample,      sample_0;
  logic           sample_valid, sample_valid_0;
  logic [SW-1:0]  sweep_count, sweep_count_0;
  logic           busy,        busy_0;
  logic           done,        done_0;

  int assert_count;
  int fail_count;

  pbit_sweep_scheduler #(
    .N_PBITS(N), .SETTLE_CYCLES(S), .SWEEP_W(SW), .SHIFT_W(SHW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .n_sweeps(n_sweeps), .sweeps_per_step(sweeps_per_step),
    .bit_shift_init(bit_shift_init), .pbit_state(pbit_state),
    .update_en(update_en), .bit_shift(bit_shift), .sample(sample),
    .sample_valid(sample_valid), .sweep_count(sweep_count),
    .busy(busy), .done(done)
  );

  pbit_sweep_scheduler #(
    .N_PBITS(N), .SETTLE_CYCLES(0), .SWEEP_W(SW), .SHIFT_W(SHW)
  ) dut0 (
    .clk(clk), .reset(reset), .start(start_0), .stop(stop),
    .n_sweeps(n_sweeps), .sweeps_per_step(sweeps_per_step),
    .bit_shift_init(bit_shift_init), .pbit_state(pbit_state),
    .update_en(update_en_0), .bit_shift(bit_shift_0), .sample(sample_0),
    .sample_valid(sample_valid_0), .sweep_count(sweep_count_0),
    .busy(busy_0), .done(done_0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected strobe in run cycle c (1-based) for settle length s
  function automatic logic [N-1:0] exp_strobe(input int c, input int s);
    int len;
    int pos;
    len = N * (1 + s) + 1;
    pos = (c - 1) % len;
    if ((pos < N * (1 + s)) && ((pos % (1 + s)) == 0))
      return N'(1) << (pos / (1 + s));
    return '0;
  endfunction

  // Expected bit_shift after k completed sweeps
  function automatic logic [SHW-1:0] exp_shift(input int init, input int sps, input int k);
`ifdef PBIT_SCHED_ANNEAL_EN
    int v;
    if (sps == 0) return SHW'(init);
    v = init - (k / sps);
    if (v < 0) v = 0;
    return SHW'(v);
`else
    return SHW'(init + 0 * (sps + k));
`endif
  endfunction

  task automatic test_reset();
    assert_count++;
    if ({update_en, bit_shift, sample, sample_valid, sweep_count, busy, done} !== '0) begin
      fail_count++;
      $display("[TB] FAIL reset_outputs: got ue=%b bs=%0d smp=%b sv=%b cnt=%0d busy=%b done=%b, expected all 0",
               update_en, bit_shift, sample, sample_valid, sweep_count, busy, done);
    end
    assert_count++;
    if ({update_en_0, sample_valid_0, sweep_count_0, busy_0, done_0} !== '0) begin
      fail_count++;
      $display("[TB] FAIL reset_outputs_s0: got ue=%b busy=%b, expected 0", update_en_0, busy_0);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_sweeps(input int n, input int sps, input int init);
    int total;
    int k;
    logic [N-1:0] e_ue;
    logic e_sv;
    n_sweeps        = SW'(n);
    sweeps_per_step = SW'(sps);
    bit_shift_init  = SHW'(init);
    pbit_state      = N'($urandom());
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total = n * L;
    for (int c = 1; c <= total + 2; c++) begin
      k    = (c <= total) ? c / L : n;
      e_ue = (c <= total) ? exp_strobe(c, S) : '0;
      e_sv = (c <= total) && ((c % L) == 0);
      assert_count++;
      if (update_en !== e_ue) begin
        fail_count++;
        $display("[TB] FAIL sweeps_update_en n=%0d c=%0d: got %b expected %b", n, c, update_en, e_ue);
      end
      assert_count++;
      if (sample_valid !== e_sv) begin
        fail_count++;
        $display("[TB] FAIL sweeps_sample_valid n=%0d c=%0d: got %b expected %b", n, c, sample_valid, e_sv);
      end
      assert_count++;
      if (done !== (c == total + 1)) begin
        fail_count++;
        $display("[TB] FAIL sweeps_done n=%0d c=%0d: got %b expected %b", n, c, done, (c == total + 1));
      end
      assert_count++;
      if (busy !== (c <= total + 1)) begin
        fail_count++;
        $display("[TB] FAIL sweeps_busy n=%0d c=%0d: got %b expected %b", n, c, busy, (c <= total + 1));
      end
      assert_count++;
      if (sweep_count !== SW'(k)) begin
        fail_count++;
        $display("[TB] FAIL sweeps_count n=%0d c=%0d: got %0d expected %0d", n, c, sweep_count, k);
      end
      assert_count++;
      if (bit_shift !== exp_shift(init, sps, k)) begin
        fail_count++;
        $display("[TB] FAIL sweeps_bit_shift n=%0d c=%0d: got %0d expected %0d", n, c, bit_shift,
                 exp_shift(init, sps, k));
      end
      if (e_sv) begin
        assert_count++;
        if (sample !== pbit_state) begin
          fail_count++;
          $display("[TB] FAIL sweeps_sample n=%0d c=%0d: got %b expected %b", n, c, sample, pbit_state);
        end
      end
      pbit_state = N'($urandom());
      @(negedge clk);
    end
  endtask

  task automatic test_stop();
    int stop_c;
    stop_c          = L + 8;
    n_sweeps        = '0;
    sweeps_per_step = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= stop_c + 3; c++) begin
      assert_count++;
      if (update_en !== ((c <= stop_c) ? exp_strobe(c, S) : N'(0))) begin
        fail_count++;
        $display("[TB] FAIL stop_update_en c=%0d: got %b", c, update_en);
      end
      assert_count++;
      if (busy !== (c <= stop_c)) begin
        fail_count++;
        $display("[TB] FAIL stop_busy c=%0d: got %b expected %b", c, busy, (c <= stop_c));
      end
      assert_count++;
      if ((sample_valid !== (c == L)) || (done !== 1'b0)) begin
        fail_count++;
        $display("[TB] FAIL stop_pulses c=%0d: got sv=%b done=%b expected sv=%b done=0", c, sample_valid, done, (c == L));
      end
      stop  = (c == stop_c);
      start = (c == stop_c + 3);
      @(negedge clk);
    end
    start = 1'b0;
    assert_count++;
    if ((sweep_count !== '0) || (update_en !== N'(1)) || (busy !== 1'b1)) begin
      fail_count++;
      $display("[TB] FAIL stop_restart: got cnt=%0d ue=%b busy=%b expected cnt=0 ue=00001 busy=1", sweep_count, update_en, busy);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    assert_count++;
    if ((busy !== 1'b0) || (update_en !== '0)) begin
      fail_count++;
      $display("[TB] FAIL stop_idle: got busy=%b ue=%b expected 0", busy, update_en);
    end
  endtask

  task automatic test_start_ignored();
    n_sweeps = SW'(1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= L + 2; c++) begin
      assert_count++;
      if ((update_en !== exp_strobe(c, S) && c <= L) || (done !== (c == L + 1)) || (busy !== (c <= L + 1))) begin
        fail_count++;
        $display("[TB] FAIL start_ignored c=%0d: got ue=%b done=%b busy=%b", c, update_en, done, busy);
      end
      start    = (c == 5);
      n_sweeps = (c == 5) ? SW'(2) : SW'(1);
      @(negedge clk);
    end
  endtask

  task automatic test_start_stop_idle();
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      assert_count++;
      if ((busy !== 1'b0) || (update_en !== '0)) begin
        fail_count++;
        $display("[TB] FAIL start_stop_idle c=%0d: got busy=%b ue=%b expected 0", c, busy, update_en);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_midrun();
    n_sweeps = SW'(1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    assert_count++;
    if ({update_en, bit_shift, sample, sample_valid, sweep_count, busy, done} !== '0) begin
      fail_count++;
      $display("[TB] FAIL reset_midrun: got ue=%b bs=%0d cnt=%0d busy=%b, expected all 0", update_en, bit_shift, sweep_count, busy);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    assert_count++;
    if ((busy !== 1'b0) || (update_en !== '0)) begin
      fail_count++;
      $display("[TB] FAIL reset_midrun_idle: got busy=%b ue=%b expected 0", busy, update_en);
    end
  endtask

  task automatic test_no_settle();
    n_sweeps = SW'(1);
    start_0 = 1'b1;
    @(negedge clk);
    start_0 = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      assert_count++;
      if (update_en_0 !== ((c <= 6) ? exp_strobe(c, 0) : N'(0))) begin
        fail_count++;
        $display("[TB] FAIL no_settle_update_en c=%0d: got %b expected %b", c, update_en_0, exp_strobe(c, 0));
      end
      assert_count++;
      if ((sample_valid_0 !== (c == 6)) || (done_0 !== (c == 7)) || (busy_0 !== (c <= 7))) begin
        fail_count++;
        $display("[TB] FAIL no_settle_pulses c=%0d: got sv=%b done=%b busy=%b", c, sample_valid_0, done_0, busy_0);
      end
      @(negedge clk);
    end
    assert_count++;
    if (sweep_count_0 !== SW'(1)) begin
      fail_count++;
      $display("[TB] FAIL no_settle_count: got %0d expected 1", sweep_count_0);
    end
  endtask

  initial begin
    assert_count    = 0;
    fail_count      = 0;
    reset           = 1'b0;
    start           = 1'b0;
    start_0         = 1'b0;
    stop            = 1'b0;
    n_sweeps        = '0;
    sweeps_per_step = '0;
    bit_shift_init  = '0;
    pbit_state      = '0;
    repeat (2) @(negedge clk);
    $display("[TB] starting pbit_sweep_scheduler tests");
    test_reset();
    test_sweeps(1, 0, int'($urandom_range(0, 3)));
    test_sweeps(3, 0, int'($urandom_range(0, 3)));
    test_sweeps(8, 2, 3);
    test_sweeps(2, 1, int'($urandom_range(1, 3)));
    test_stop();
    test_start_ignored();
    test_start_stop_idle();
    test_reset_midrun();
    test_no_settle();
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
